// File: rtl/usb_ep_bd_mgr_if.sv
// usb_ep_bd_mgr_if: token, EP status RAM, BD context and writeback signals of the BD manager
interface usb_ep_bd_mgr_if #(
   parameter int NUM_EP = 16,
   parameter int BD_PER_EP = 2
);
   localparam int EPB = $clog2(NUM_EP);
   localparam int BDB = $clog2(BD_PER_EP) > 1 ? $clog2(BD_PER_EP) : 1;
   localparam int AW = EPB + BDB + 3;
   logic tok_stb, tok_dir, tok_setup;
   logic [EPB-1:0] tok_endp;
   logic eps_read_0, eps_write_0;
   logic [AW-1:0] eps_addr_0;
   logic [15:0] eps_wrdata_0, eps_rddata_3;
   logic info_valid, ep_dt, busy, tok_drop;
   logic [2:0] ep_type, bd_state;
   logic [BDB-1:0] bd_idx;
   logic [9:0] bd_len;
   logic [10:0] bd_addr;
   logic wb_stb, wb_dt_flip, wb_bd_adv, wb_state_set;
   logic [2:0] wb_state;
   logic [9:0] wb_xfer_len;
   modport master (
      output tok_stb, tok_endp, tok_dir, tok_setup, eps_rddata_3,
             wb_stb, wb_dt_flip, wb_bd_adv, wb_state_set, wb_state, wb_xfer_len,
      input  eps_read_0, eps_write_0, eps_addr_0, eps_wrdata_0, info_valid, ep_type, ep_dt,
             bd_idx, bd_state, bd_len, bd_addr, busy, tok_drop
   );
   modport slave (
      input  tok_stb, tok_endp, tok_dir, tok_setup, eps_rddata_3,
             wb_stb, wb_dt_flip, wb_bd_adv, wb_state_set, wb_state, wb_xfer_len,
      output eps_read_0, eps_write_0, eps_addr_0, eps_wrdata_0, info_valid, ep_type, ep_dt,
             bd_idx, bd_state, bd_len, bd_addr, busy, tok_drop
   );
endinterface

// File: rtl/usb_ep_bd_mgr.sv
// usb_ep_bd_mgr: fetches EP status and current BD on a token, writes status and BD word 0 back on command
module usb_ep_bd_mgr #(
   parameter int NUM_EP = 16,
   parameter int BD_PER_EP = 2,
   parameter int RD_LAT = 3
) (
   input logic clk,
   input logic rst,
   usb_ep_bd_mgr_if.slave bus
);
   localparam int EPB = $clog2(NUM_EP);
   localparam int BDB = $clog2(BD_PER_EP) > 1 ? $clog2(BD_PER_EP) : 1;
   localparam logic [1:0] IDX_MASK = BDB > 1 ? 2'b11 : 2'b01;
   typedef enum logic [2:0] {IDLE, RD_ST, WAIT_ST, RD_W0, RD_W1, WAIT_BD, WB_ST, WB_W0} state_t;
   typedef enum logic [1:0] {T_NONE, T_ST, T_W0, T_W1} tag_t;
   state_t state, state_nxt;
   tag_t rd_pipe [RD_LAT];
   tag_t rd_tag;
   logic [EPB-1:0] cur_endp, pend_endp;
   logic cur_dir, cur_setup, pend_dir, pend_setup, pend_full;
   logic [2:0] typ, bd_state;
   logic multi, ctrl, dt, bd_setup, info_valid, tok_drop, sel_bd;
   logic [1:0] idx_nxt, ring_last;
   logic [BDB-1:0] bd_idx;
   logic [9:0] bd_len, wb_len;
   logic [10:0] bd_addr;
   logic [15:0] d;
   logic wb_acc, go, tok_take, tok_pend, drop;
   assign d = bus.eps_rddata_3;
   assign rd_tag = rd_pipe[RD_LAT-1];
   assign wb_acc = bus.wb_stb & info_valid & state == IDLE & !pend_full;
   assign tok_take = bus.tok_stb & state == IDLE & !pend_full & !wb_acc;
   assign go = state == IDLE & pend_full | tok_take;
   // a token colliding with a writeback waits in the one-deep slot
   assign tok_pend = bus.tok_stb & !pend_full & (state inside {WB_ST, WB_W0} | wb_acc);
   assign drop = bus.tok_stb & !tok_take & !tok_pend;
   assign bus.info_valid = info_valid;
   assign bus.tok_drop = tok_drop;
   assign bus.busy = state != IDLE | pend_full;
   assign bus.ep_type = typ;
   assign bus.ep_dt = dt;
   assign bus.bd_idx = bd_idx;
   assign bus.bd_state = bd_state;
   assign bus.bd_len = bd_len;
   assign bus.bd_addr = bd_addr;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = go ? RD_ST : wb_acc ? WB_ST : IDLE;
         RD_ST:   state_nxt = WAIT_ST;
         WAIT_ST: state_nxt = rd_tag == T_ST ? RD_W0 : WAIT_ST;
         RD_W0:   state_nxt = RD_W1;
         RD_W1:   state_nxt = WAIT_BD;
         WAIT_BD: state_nxt = rd_tag == T_W1 ? IDLE : WAIT_BD;
         WB_ST:   state_nxt = WB_W0;
         default: state_nxt = IDLE;
      endcase
      sel_bd = !(state inside {RD_ST, WB_ST});
      bus.eps_read_0 = state inside {RD_ST, RD_W0, RD_W1};
      bus.eps_write_0 = state inside {WB_ST, WB_W0};
      bus.eps_addr_0 = {cur_endp, cur_dir, sel_bd, sel_bd ? bd_idx : BDB'(0), state == RD_W1};
      bus.eps_wrdata_0 = state == WB_ST ? {4'h0, ring_last, idx_nxt, dt, 1'b0, ctrl, multi, 1'b0, typ}
                                        : {bd_state, bd_setup, 2'b00, wb_len};
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         info_valid <= 1'b0;
         tok_drop <= 1'b0;
         pend_full <= 1'b0;
         rd_pipe <= '{default: T_NONE};
      end else begin
         state <= state_nxt;
         tok_drop <= drop;
         pend_full <= tok_pend | pend_full & state != IDLE;
         rd_pipe[0] <= state == RD_ST ? T_ST : state == RD_W0 ? T_W0 : state == RD_W1 ? T_W1 : T_NONE;
         for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
         info_valid <= go ? 1'b0 : rd_tag == T_W1 ? 1'b1 : info_valid;
      end
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (go) begin
            cur_endp <= pend_full ? pend_endp : bus.tok_endp;
            cur_dir <= pend_full ? pend_dir : bus.tok_dir;
            cur_setup <= pend_full ? pend_setup : bus.tok_setup;
         end
         if (tok_pend) begin
            pend_endp <= bus.tok_endp;
            pend_dir <= bus.tok_dir;
            pend_setup <= bus.tok_setup;
         end
         // SETUP always starts DATA0; control EPs pick BD 1 for SETUP, BD 0 otherwise
         if (rd_tag == T_ST) begin
            typ <= d[2:0];
            multi <= d[4];
            ctrl <= d[5];
            dt <= d[7] & !cur_setup;
            idx_nxt <= d[9:8] & IDX_MASK;
            ring_last <= d[11:10] & IDX_MASK;
            bd_idx <= d[5] ? BDB'(cur_setup) : BDB'(d[9:8] & IDX_MASK);
         end
         if (rd_tag == T_W0) begin
            bd_state <= d[15:13];
            bd_setup <= d[12];
            bd_len <= d[9:0];
         end
         if (rd_tag == T_W1) bd_addr <= d[10:0];
         if (wb_acc) begin
            dt <= dt ^ bus.wb_dt_flip;
            if (bus.wb_bd_adv & multi) idx_nxt <= idx_nxt == ring_last ? 2'b00 : (idx_nxt + 2'b01) & IDX_MASK;
            if (bus.wb_state_set) bd_state <= bus.wb_state;
            wb_len <= bus.wb_xfer_len;
         end
      end
   end
endmodule

// File: tb/tb_usb_ep_bd_mgr.sv
// tb_usb_ep_bd_mgr: directed bench with an EP RAM model and read/write scoreboards
module tb_usb_ep_bd_mgr;
   localparam int NUM_EP = 16, BD_PER_EP = 4, RD_LAT = 3;
   localparam int AW = 4 + 2 + 3;
   logic clk = 1'b0, rst = 1'b1;
   int checks = 0, errors = 0;
   logic [15:0] mem [2**AW];
   logic [AW-1:0] pipe_a [RD_LAT];
   logic pipe_v [RD_LAT] = '{default: 1'b0};
   logic [AW-1:0] exp_rd [$];
   logic [AW+15:0] exp_wr [$];
   usb_ep_bd_mgr_if #(.NUM_EP(NUM_EP), .BD_PER_EP(BD_PER_EP)) bus ();
   usb_ep_bd_mgr #(.NUM_EP(NUM_EP), .BD_PER_EP(BD_PER_EP), .RD_LAT(RD_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) begin
      pipe_v[0] <= bus.eps_read_0;
      pipe_a[0] <= bus.eps_addr_0;
      for (int i = 1; i < RD_LAT; i++) begin
         pipe_v[i] <= pipe_v[i-1];
         pipe_a[i] <= pipe_a[i-1];
      end
   end
   assign bus.eps_rddata_3 = pipe_v[RD_LAT-1] === 1'b1 ? mem[pipe_a[RD_LAT-1]] : 16'hDEAD;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   always @(negedge clk) begin
      if (bus.eps_read_0 | bus.eps_write_0) chk("rw_excl", 32'(bus.eps_read_0 & bus.eps_write_0), 0);
      if (bus.eps_read_0) begin
         chk("rd_expected", 32'(exp_rd.size() > 0), 1);
         if (exp_rd.size() > 0) chk("rd_addr", 32'(bus.eps_addr_0), 32'(exp_rd.pop_front()));
      end
      if (bus.eps_write_0) begin
         chk("wr_expected", 32'(exp_wr.size() > 0), 1);
         if (exp_wr.size() > 0) chk("wr_addr_data", 32'({bus.eps_addr_0, bus.eps_wrdata_0}), 32'(exp_wr.pop_front()));
      end
   end
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   function automatic logic [AW-1:0] a(input int endp, input int dir, input int sel, input int idx, input int word);
      return {4'(endp), 1'(dir), 1'(sel), 2'(idx), 1'(word)};
   endfunction
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic prime(input int endp, input int dir, input logic [15:0] st, w0, w1, input int idx);
      mem[a(endp, dir, 0, 0, 0)] = st;
      mem[a(endp, dir, 1, idx, 0)] = w0;
      mem[a(endp, dir, 1, idx, 1)] = w1;
      exp_rd.push_back(a(endp, dir, 0, 0, 0));
      exp_rd.push_back(a(endp, dir, 1, idx, 0));
      exp_rd.push_back(a(endp, dir, 1, idx, 1));
   endtask
   task automatic tok(input int endp, input int dir, input int setup);
      bus.tok_stb = 1'b1;
      bus.tok_endp = 4'(endp);
      bus.tok_dir = 1'(dir);
      bus.tok_setup = 1'(setup);
      tick();
      bus.tok_stb = 1'b0;
   endtask
   task automatic wait_iv(input string tag, input int n0, input int exp_n);
      int n = n0;
      while (bus.info_valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk(tag, n, exp_n);
   endtask
   task automatic ctx(input string tag, input int typ, dt, idx, state, len, addr);
      chk({tag, "_type"}, 32'(bus.ep_type), typ);
      chk({tag, "_dt"}, 32'(bus.ep_dt), dt);
      chk({tag, "_idx"}, 32'(bus.bd_idx), idx);
      chk({tag, "_state"}, 32'(bus.bd_state), state);
      chk({tag, "_len"}, 32'(bus.bd_len), len);
      chk({tag, "_addr"}, 32'(bus.bd_addr), addr);
   endtask
   task automatic set_wb(input int flip, adv, set, wstate, xfer);
      bus.wb_dt_flip = 1'(flip);
      bus.wb_bd_adv = 1'(adv);
      bus.wb_state_set = 1'(set);
      bus.wb_state = 3'(wstate);
      bus.wb_xfer_len = 10'(xfer);
   endtask
   task automatic wb(input string tag, input int flip, adv, set, wstate, xfer, endp, dir, idx, input logic [15:0] st, w0);
      exp_wr.push_back({a(endp, dir, 0, 0, 0), st});
      exp_wr.push_back({a(endp, dir, 1, idx, 0), w0});
      set_wb(flip, adv, set, wstate, xfer);
      bus.wb_stb = 1'b1;
      tick();
      bus.wb_stb = 1'b0;
      chk({tag, "_wr1"}, 32'(bus.eps_write_0), 1);
      tick();
      chk({tag, "_wr2"}, 32'(bus.eps_write_0), 1);
      tick();
      chk({tag, "_wr_end"}, 32'(bus.eps_write_0), 0);
      chk({tag, "_iv_kept"}, 32'(bus.info_valid), 1);
      chk({tag, "_idle"}, 32'(bus.busy), 0);
   endtask
   initial begin
      bit iv_seen;
      for (int i = 0; i < 2**AW; i++) mem[i] = 16'h0;
      bus.tok_stb = 1'b0;
      bus.tok_endp = '0;
      bus.tok_dir = 1'b0;
      bus.tok_setup = 1'b0;
      bus.wb_stb = 1'b0;
      set_wb(0, 0, 0, 0, 0);
      repeat (3) tick();
      chk("rst_info_valid", 32'(bus.info_valid), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_tok_drop", 32'(bus.tok_drop), 0);
      chk("rst_read", 32'(bus.eps_read_0), 0);
      chk("rst_write", 32'(bus.eps_write_0), 0);
      rst = 1'b0;
      tick();
      prime(2, 0, 16'h0080, 16'h2040, 16'h0100, 0);
      tok(2, 0, 0);
      chk("ep2_busy", 32'(bus.busy), 1);
      wait_iv("ep2_latency", 1, 10);
      ctx("ep2", 0, 1, 0, 1, 64, 'h100);
      wb("wb_flip", 1, 0, 1, 2, 5, 2, 0, 0, 16'h0000, 16'h4005);
      chk("wb_flip_dt", 32'(bus.ep_dt), 0);
      chk("wb_flip_state", 32'(bus.bd_state), 2);
      prime(5, 1, 16'h0A12, 16'h8010, 16'h0123, 2);
      tok(5, 1, 0);
      wait_iv("ring_latency", 1, 10);
      ctx("ring", 2, 0, 2, 4, 16, 'h123);
      wb("ring_wrap", 0, 1, 0, 0, 16, 5, 1, 2, 16'h0812, 16'h8010);
      wb("ring_inc", 0, 1, 0, 0, 7, 5, 1, 2, 16'h0912, 16'h8007);
      prime(0, 0, 16'h00A0, 16'h7008, 16'h0040, 1);
      tok(0, 0, 1);
      wait_iv("setup_latency", 1, 10);
      ctx("setup", 0, 0, 1, 3, 8, 'h040);
      wb("setup_wb", 1, 0, 0, 0, 8, 0, 0, 1, 16'h00A0, 16'h7008);
      prime(0, 0, 16'h00A0, 16'h2010, 16'h0050, 0);
      tok(0, 0, 0);
      wait_iv("ctrl_out_latency", 1, 10);
      ctx("ctrl_out", 0, 1, 0, 1, 16, 'h050);
      prime(2, 0, 16'h0003, 16'hA00C, 16'h0200, 0);
      exp_wr.push_back({a(0, 0, 0, 0, 0), 16'h00A0});
      exp_wr.push_back({a(0, 0, 1, 0, 0), 16'h2003});
      set_wb(0, 0, 0, 0, 3);
      bus.wb_stb = 1'b1;
      tick();
      bus.wb_stb = 1'b0;
      chk("pend_wr1", 32'(bus.eps_write_0), 1);
      tok(2, 0, 0);
      chk("pend_busy", 32'(bus.busy), 1);
      chk("pend_no_drop", 32'(bus.tok_drop), 0);
      tick();
      chk("pend_no_drop2", 32'(bus.tok_drop), 0);
      tick();
      wait_iv("pend_latency", 1, 10);
      ctx("pend", 3, 0, 0, 5, 12, 'h200);
      prime(7, 1, 16'h0004, 16'h2020, 16'h0300, 0);
      tok(7, 1, 0);
      repeat (2) tick();
      tok(9, 0, 0);
      chk("drop_pulse", 32'(bus.tok_drop), 1);
      tick();
      chk("drop_pulse_end", 32'(bus.tok_drop), 0);
      wait_iv("drop_latency", 5, 10);
      ctx("drop", 4, 0, 0, 1, 32, 'h300);
      chk("drop_no_pending", 32'(bus.busy), 0);
      mem[a(3, 0, 0, 0, 0)] = 16'h0080;
      mem[a(3, 0, 1, 0, 0)] = 16'hE3FF;
      exp_rd.push_back(a(3, 0, 0, 0, 0));
      exp_rd.push_back(a(3, 0, 1, 0, 0));
      tok(3, 0, 0);
      repeat (4) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_iv", 32'(bus.info_valid), 0);
      chk("midrst_busy", 32'(bus.busy), 0);
      bus.wb_stb = 1'b1;
      tick();
      bus.wb_stb = 1'b0;
      chk("wb_ignored", 32'(bus.eps_write_0), 0);
      iv_seen = 1'b0;
      repeat (10) begin
         tick();
         iv_seen |= bus.info_valid;
      end
      chk("midrst_iv_stays_low", 32'(iv_seen), 0);
      prime(3, 0, 16'h0001, 16'h6030, 16'h0345, 0);
      tok(3, 0, 0);
      wait_iv("after_rst_latency", 1, 10);
      ctx("after_rst", 1, 0, 0, 3, 48, 'h345);
      repeat (3) tick();
      chk("rd_left", exp_rd.size(), 0);
      chk("wr_left", exp_wr.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
